sha3_block_sequencer: RTL
=========================

// Module: sha3_block_sequencer
// PURPOSE
//  Feeds multi-block messages into the sha3 core: accepts rate-sized blocks over a valid/ready stream,
//  issues start plus sha3_ctrl, swaps in each next block at the core's fixed absorb boundary,
//  and returns the digest over a valid/ready stream.
//  Double-buffers input blocks. Detects underrun, length mismatch and a hung core.
// PARAMETERS
//  BLOCK_CYCLES  24     cycles the core spends per absorbed block; next block is sampled at this boundary
//  TIMEOUT       1024   max cycles in WAIT_DONE/DRAIN before abort
// PORTS
//  clk            in   1     clock, rising edge
//  reset          in   1     asynchronous, active-high reset
//  cfg_mode       in   3     SHA3 variant code (3'b010 = SHA3-224); sampled with the first block
//  cfg_nblk       in   7     number of blocks minus 1; sampled with the first block
//  msg_valid      in   1     block beat valid
//  msg_ready      out  1     block beat accepted when valid&ready
//  msg_data       in   1152  padded block, MSB-first as the core expects
//  msg_last       in   1     marks the final block of the message
//  sha3_start     out  1     one-cycle start pulse to the core
//  sha3_ctrl      out  10    {cfg_nblk, cfg_mode} to the core
//  sha3_in        out  1152  current block to the core
//  sha3_done      in   1     core completion
//  sha3_out       in   512   core digest
//  dig_valid      out  1     digest valid; held until dig_ready
//  dig_ready      in   1     digest consumer ready
//  dig_data       out  512   captured digest
//  busy           out  1     state != IDLE
//  err_underrun   out  1     sticky: next block was not staged at the swap boundary
//  err_len        out  1     sticky: msg_last disagreed with cfg_nblk
//  err_timeout    out  1     sticky: core did not signal done within TIMEOUT cycles
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, staging empty, counters 0.
//    Any reset assertion mid-message aborts immediately; no digest is produced.
//  States: IDLE, START, ABSORB, WAIT_DONE, OUT, DRAIN.
//  IDLE: msg_ready=1. A beat loads cur (drives sha3_in) and latches cfg_mode and cfg_nblk.
//    All err_* flags clear on this beat. Then go to START.
//    If msg_last=1 and cfg_nblk!=0: set err_len and go to IDLE (no start).
//  START: sha3_start=1 for exactly one cycle; sha3_ctrl={nblk,mode} is stable from this cycle to the end of the message.
//    Set blk_idx=0, cnt=0. Go to ABSORB if nblk>0, else WAIT_DONE.
//  ABSORB: cnt increments each cycle. msg_ready = staging empty.
//    Each accepted beat goes to staging. err_len is set if msg_last != (staged index == nblk).
//    On err_len, go to DRAIN.
//  At cnt==BLOCK_CYCLES-1:
//    - Staging full: move staging to cur, so sha3_in changes the next cycle. blk_idx++, cnt=0.
//      When blk_idx reaches nblk, go to WAIT_DONE.
//    - Staging empty: set err_underrun and go to DRAIN.
//    - A beat accepted in this same cycle counts as staged; it is forwarded to cur directly.
//  WAIT_DONE: msg_ready=0. On sha3_done: dig_data<=sha3_out, dig_valid=1, go to OUT.
//  OUT: hold dig_valid and dig_data until dig_ready, then go to IDLE.
//    dig_valid&dig_ready in the same cycle as a new msg_valid: the beat waits one cycle (IDLE accepts it).
//  DRAIN: msg_ready=0. Wait for sha3_done, discard the digest, go to IDLE. dig_valid stays 0.
//  Timeout: in WAIT_DONE or DRAIN, a counter runs. At TIMEOUT, set err_timeout, go to IDLE.
//    The core is not reset by this block.
//  sha3_done outside WAIT_DONE/DRAIN is ignored.
//  Latency: first beat to sha3_start = 1 cycle. sha3_done to dig_valid = 1 cycle.
// TESTING
//  1 block, mode 3'b010, nblk 0, data a5eb..99 padded ...80
//    -> one sha3_start, sha3_ctrl=10'b0000000010, dig_valid 1 cycle after sha3_done, dig_data==sha3_out.
//  2 blocks, nblk 1, second block 45eb..a906...80 sent right after the first
//    -> sha3_ctrl=10'b0000001010; sha3_in switches exactly BLOCK_CYCLES cycles after start; one digest.
//  2 blocks, second beat withheld past the boundary
//    -> err_underrun=1, DRAIN, no dig_valid; next message clears the error.
//  nblk=1 with msg_last=1 on the first beat -> err_len=1, no sha3_start, msg_ready=1 next cycle.
//  Core never asserts done -> err_timeout after exactly TIMEOUT cycles, busy=0.
//    dig_ready held 0 for 10 cycles -> dig_data stable throughout.
//  reset pulsed during ABSORB -> all outputs 0 asynchronously; a fresh message completes normally.

Source files
------------

// File: rtl/sha3_block_sequencer_if.sv
//------------------------------------------------------------------------------
// Module   : sha3_block_sequencer_if
// Brief    : Message-block input stream, per-message configuration and digest
//            output stream of the SHA3 block sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sha3_block_sequencer_if;
  logic [2:0]    cfg_mode;
  logic [6:0]    cfg_nblk;
  logic          msg_valid;
  logic          msg_ready;
  logic [1151:0] msg_data;
  logic          msg_last;
  logic          dig_valid;
  logic          dig_ready;
  logic [511:0]  dig_data;

  // Message source and digest sink
  modport master (
    output cfg_mode, cfg_nblk, msg_valid, msg_data, msg_last, dig_ready,
    input  msg_ready, dig_valid, dig_data
  );

  // Sequencer side
  modport slave (
    input  cfg_mode, cfg_nblk, msg_valid, msg_data, msg_last, dig_ready,
    output msg_ready, dig_valid, dig_data
  );
endinterface

`default_nettype wire

// File: rtl/sha3_block_sequencer.sv
//------------------------------------------------------------------------------
// Module   : sha3_block_sequencer
// Brief    : Feeds multi-block padded messages into the SHA3 core. Blocks are
//            double-buffered (cur + staging); the staged block is moved into
//            cur at each fixed absorb boundary of the core. Returns the digest
//            over a valid/ready stream and flags underrun, length mismatch and
//            core timeout.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sha3_block_sequencer #(
  parameter int BLOCK_CYCLES = 24,
  parameter int TIMEOUT      = 1024
) (
  input  wire logic              clk,
  input  wire logic              reset,
  sha3_block_sequencer_if.slave  bus,
  output logic                   sha3_start,
  output logic [9:0]             sha3_ctrl,
  output logic [1151:0]          sha3_in,
  input  wire logic              sha3_done,
  input  wire logic [511:0]      sha3_out,
  output logic                   busy,
  output logic                   err_underrun,
  output logic                   err_len,
  output logic                   err_timeout
);

  localparam int c_CNT_W = (BLOCK_CYCLES > 1) ? $clog2(BLOCK_CYCLES) : 1;
  localparam int c_TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BLOCK_CYCLES - 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_ABSORB    = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_OUT       = 3'd4,
    S_DRAIN     = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_live;       // 0 while reset is held, so msg_ready is 0 in reset
  logic [1151:0]        r_cur;
  logic [1151:0]        r_stg;
  logic                 r_stg_full;
  logic [2:0]           r_mode;
  logic [6:0]           r_nblk;
  logic [6:0]           r_blk_idx;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_TMO_W-1:0]   r_tmo;
  logic                 r_dig_valid;
  logic [511:0]         r_dig_data;
  logic                 r_err_underrun;
  logic                 r_err_len;
  logic                 r_err_timeout;

  logic                 w_ready;
  logic                 w_accept;
  logic                 w_stg_is_last;
  logic                 w_len_bad;
  logic                 w_boundary;
  logic                 w_staged;
  logic                 w_tmo_hit;

  // Handshake qualifiers and absorb-boundary decode
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      S_IDLE:   w_ready = r_live;
      S_ABSORB: w_ready = ~r_stg_full;
      default:  w_ready = 1'b0;
    endcase
    w_accept      = bus.msg_valid & w_ready;
    // The beat being staged is block blk_idx+1; it must be the last one exactly when that index is nblk
    w_stg_is_last = (7'(r_blk_idx + 7'd1) == r_nblk);
    w_len_bad     = (r_state == S_ABSORB) & w_accept & (bus.msg_last != w_stg_is_last);
    w_boundary    = (r_cnt == c_CNT_LAST);
    w_staged      = r_stg_full | w_accept;
    w_tmo_hit     = (r_tmo == c_TMO_LAST);
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (bus.msg_last && (bus.cfg_nblk != 7'd0)) w_next = S_IDLE;
          else                                        w_next = S_START;
        end
      end
      S_START: begin
        w_next = (r_nblk != 7'd0) ? S_ABSORB : S_WAIT_DONE;
      end
      S_ABSORB: begin
        if (w_len_bad) begin
          w_next = S_DRAIN;
        end else if (w_boundary) begin
          if (!w_staged)          w_next = S_DRAIN;
          else if (w_stg_is_last) w_next = S_WAIT_DONE;
          else                    w_next = S_ABSORB;
        end
      end
      S_WAIT_DONE: begin
        if (sha3_done)      w_next = S_OUT;
        else if (w_tmo_hit) w_next = S_IDLE;
      end
      S_OUT: begin
        if (bus.dig_ready) w_next = S_IDLE;
      end
      S_DRAIN: begin
        if (sha3_done || w_tmo_hit) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Block buffers, counters, digest capture and sticky error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_live         <= 1'b0;
      r_cur          <= '0;
      r_stg          <= '0;
      r_stg_full     <= 1'b0;
      r_mode         <= '0;
      r_nblk         <= '0;
      r_blk_idx      <= '0;
      r_cnt          <= '0;
      r_tmo          <= '0;
      r_dig_valid    <= 1'b0;
      r_dig_data     <= '0;
      r_err_underrun <= 1'b0;
      r_err_len      <= 1'b0;
      r_err_timeout  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cur          <= bus.msg_data;
            r_mode         <= bus.cfg_mode;
            r_nblk         <= bus.cfg_nblk;
            r_stg_full     <= 1'b0;
            r_cnt          <= '0;
            r_err_underrun <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_len      <= bus.msg_last & (bus.cfg_nblk != 7'd0);
          end
        end
        S_START: begin
          // The START cycle is absorb cycle 0, so the first swap lands
          // exactly BLOCK_CYCLES cycles after the start pulse
          r_blk_idx <= '0;
          r_cnt     <= c_CNT_W'(1);
          r_tmo     <= '0;
        end
        S_ABSORB: begin
          r_cnt <= r_cnt + c_CNT_W'(1);
          if (w_len_bad) begin
            r_err_len <= 1'b1;
            r_tmo     <= '0;
          end else if (w_boundary) begin
            r_tmo <= '0;
            if (w_staged) begin
              // A beat accepted on the boundary cycle bypasses staging
              r_cur      <= r_stg_full ? r_stg : bus.msg_data;
              r_stg_full <= 1'b0;
              r_blk_idx  <= r_blk_idx + 7'd1;
              r_cnt      <= '0;
            end else begin
              r_err_underrun <= 1'b1;
            end
          end else if (w_accept) begin
            r_stg      <= bus.msg_data;
            r_stg_full <= 1'b1;
          end
        end
        S_WAIT_DONE: begin
          r_tmo <= r_tmo + c_TMO_W'(1);
          if (sha3_done) begin
            r_dig_data  <= sha3_out;
            r_dig_valid <= 1'b1;
          end else if (w_tmo_hit) begin
            r_err_timeout <= 1'b1;
          end
        end
        S_OUT: begin
          if (bus.dig_ready) r_dig_valid <= 1'b0;
        end
        S_DRAIN: begin
          r_tmo <= r_tmo + c_TMO_W'(1);
          if (!sha3_done && w_tmo_hit) r_err_timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.msg_ready = w_ready;
  assign bus.dig_valid = r_dig_valid;
  assign bus.dig_data  = r_dig_data;
  assign sha3_start    = (r_state == S_START);
  assign sha3_ctrl     = {r_nblk, r_mode};
  assign sha3_in       = r_cur;
  assign busy          = (r_state != S_IDLE);
  assign err_underrun  = r_err_underrun;
  assign err_len       = r_err_len;
  assign err_timeout   = r_err_timeout;

endmodule

`default_nettype wire
